// File: rtl/light_sweep_sequencer_if.sv
// Handshake bundle between the light-show state machine (master) and the sweep
// sequencer (slave): run controls in, LED drive and progress counters back.
interface light_sweep_sequencer_if;
    logic       enable;
    logic [1:0] state;
    logic [9:0] ledPattern;
    logic [5:0] count;
    logic [3:0] repCount;
    logic       tick;

    modport master (
        output enable, state,
        input  ledPattern, count, repCount, tick
    );

    modport slave (
        input  enable, state,
        output ledPattern, count, repCount, tick
    );
endinterface

// File: rtl/light_sweep_sequencer.sv
// Turns the state machine's delay-state and run enable into a 10-LED pattern,
// stepping a fill sweep or a full-on/off blink at a per-state tick rate.
module light_sweep_sequencer #(
    parameter int unsigned TICKS_2S   = 100_000_000,
    parameter int unsigned TICKS_0P1S = 5_000_000,
    parameter int unsigned TICKS_1S   = 50_000_000,
    parameter int unsigned REPS       = 4
) (
    input logic                    clk,
    input logic                    reset,
    light_sweep_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SWEEP = 2'b01;
    localparam logic [1:0] ST_FINAL = 2'b10;

    localparam logic [5:0] LAST_STEP = 6'd10;
    localparam logic [3:0] REPS_INIT = 4'(REPS);
    localparam logic [9:0] ALL_ON    = 10'h3FF;

    logic [31:0] presc_p0;
    logic [1:0]  prev_state_p0;
    logic [9:0]  led_p0;
    logic [5:0]  count_p0;
    logic [3:0]  rep_p0;
    logic        tick_p0;

    logic [31:0] period_m1;
    logic        state_change;

    // Fill pattern: the lowest n LEDs lit, i.e. (1<<n)-1 clipped to 10 LEDs.
    function automatic logic [9:0] fill_pattern(input logic [5:0] n);
        logic [9:0] p;
        p = '0;
        for (int i = 0; i < 10; i++) begin
            if (6'(i) < n) p[i] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    always_comb begin
        period_m1 = TICKS_2S - 32'd1;
        case (bus.state)
            ST_SWEEP: period_m1 = TICKS_0P1S - 32'd1;
            ST_FINAL: period_m1 = TICKS_1S - 32'd1;
            default:  period_m1 = TICKS_2S - 32'd1;
        endcase
    end

    assign state_change = (bus.state != prev_state_p0);

    // A state change takes priority over both enable and a pending tick, so the
    // new state always starts from a clean prescaler and step index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_p0      <= '0;
            prev_state_p0 <= ST_IDLE;
            led_p0        <= '0;
            count_p0      <= '0;
            rep_p0        <= REPS_INIT;
            tick_p0       <= 1'b0;
        end else begin
            prev_state_p0 <= bus.state;
            if (state_change) begin
                presc_p0 <= '0;
                count_p0 <= '0;
                tick_p0  <= 1'b0;
                case (bus.state)
                    ST_SWEEP: led_p0 <= fill_pattern(6'd0);
                    ST_FINAL: led_p0 <= ALL_ON;
                    default: begin
                        led_p0 <= '0;
                        rep_p0 <= REPS_INIT;
                    end
                endcase
            end else if (bus.enable) begin
                if (presc_p0 == period_m1) begin
                    presc_p0 <= '0;
                    tick_p0  <= 1'b1;
                end else begin
                    presc_p0 <= presc_p0 + 32'd1;
                    tick_p0  <= 1'b0;
                end
                if (tick_p0) begin
                    case (bus.state)
                        ST_SWEEP: begin
                            if (count_p0 < LAST_STEP) begin
                                count_p0 <= count_p0 + 6'd1;
                                led_p0   <= fill_pattern(count_p0 + 6'd1);
                            end else begin
                                count_p0 <= '0;
                                led_p0   <= fill_pattern(6'd0);
                                rep_p0   <= sat_dec(rep_p0);
                            end
                        end
                        ST_FINAL: begin
                            count_p0 <= '0;
                            led_p0   <= ~led_p0;
                        end
                        default: begin
                            count_p0 <= '0;
                            led_p0   <= '0;
                        end
                    endcase
                end
            end else begin
                tick_p0 <= 1'b0;
            end
        end
    end

    assign bus.ledPattern = led_p0;
    assign bus.count      = count_p0;
    assign bus.repCount   = rep_p0;
    assign bus.tick       = tick_p0;

endmodule

// File: tb/tb_light_sweep_sequencer.sv
// Directed bench for light_sweep_sequencer with short periods (4/2/3 clks, 2 reps).
module tb_light_sweep_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    logic [9:0] fill_tab [11] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                                  10'h01F, 10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF};

    light_sweep_sequencer_if bus ();

    light_sweep_sequencer #(
        .TICKS_2S  (4),
        .TICKS_0P1S(2),
        .TICKS_1S  (3),
        .REPS      (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.enable = 1'b0;
        bus.state  = 2'b00;
        step(2);
        chk("rst_led", 32'(bus.ledPattern), 32'h000);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_rep", 32'(bus.repCount), 32'd2);
        chk("rst_tick", 32'(bus.tick), 32'd0);
        reset = 1'b0;

        // Sweep from reset: entry cycle, then a tick every 2 clks.
        bus.enable = 1'b1;
        bus.state  = 2'b01;
        step(1);
        chk("sw_entry_count", 32'(bus.count), 32'd0);
        chk("sw_entry_led", 32'(bus.ledPattern), 32'h000);
        chk("sw_entry_tick", 32'(bus.tick), 32'd0);
        step(1);
        chk("sw_pre_tick", 32'(bus.tick), 32'd0);
        step(1);
        chk("sw_first_tick", 32'(bus.tick), 32'd1);
        chk("sw_first_tick_count", 32'(bus.count), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("sw_count", 32'(bus.count), 32'(k));
            chk("sw_led", 32'(bus.ledPattern), 32'(fill_tab[k]));
            chk("sw_tick_low", 32'(bus.tick), 32'd0);
            chk("sw_rep_hold", 32'(bus.repCount), 32'd2);
            step(1);
            chk("sw_tick_high", 32'(bus.tick), 32'd1);
        end
        step(1);
        chk("wrap1_count", 32'(bus.count), 32'd0);
        chk("wrap1_led", 32'(bus.ledPattern), 32'h000);
        chk("wrap1_rep", 32'(bus.repCount), 32'd1);

        // Further wraps: repCount reaches 0 and saturates there.
        step(22);
        chk("wrap2_count", 32'(bus.count), 32'd0);
        chk("wrap2_rep", 32'(bus.repCount), 32'd0);
        step(22);
        chk("wrap3_rep", 32'(bus.repCount), 32'd0);
        step(22);
        chk("wrap4_rep", 32'(bus.repCount), 32'd0);
        chk("wrap4_led", 32'(bus.ledPattern), 32'h000);

        // Enable dropped for 10 clks at count 3 with the prescaler one short of a tick.
        step(6);
        chk("pre_hold_count", 32'(bus.count), 32'd3);
        chk("pre_hold_led", 32'(bus.ledPattern), 32'h007);
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hold_tick", 32'(bus.tick), 32'd0);
            chk("hold_count", 32'(bus.count), 32'd3);
        end
        chk("hold_led", 32'(bus.ledPattern), 32'h007);
        chk("hold_rep", 32'(bus.repCount), 32'd0);
        bus.enable = 1'b1;
        step(1);
        chk("resume_tick", 32'(bus.tick), 32'd1);
        chk("resume_count", 32'(bus.count), 32'd3);
        step(1);
        chk("resume_step_count", 32'(bus.count), 32'd4);
        chk("resume_step_led", 32'(bus.ledPattern), 32'h00F);

        // Sweep -> final blink at count 7; the tick due on the entry cycle is dropped.
        step(6);
        chk("pre_final_count", 32'(bus.count), 32'd7);
        chk("pre_final_led", 32'(bus.ledPattern), 32'h07F);
        bus.state = 2'b10;
        step(1);
        chk("final_entry_count", 32'(bus.count), 32'd0);
        chk("final_entry_led", 32'(bus.ledPattern), 32'h3FF);
        chk("final_entry_tick", 32'(bus.tick), 32'd0);
        step(2);
        chk("final_pre_tick", 32'(bus.tick), 32'd0);
        chk("final_pre_led", 32'(bus.ledPattern), 32'h3FF);
        step(1);
        chk("final_tick", 32'(bus.tick), 32'd1);
        step(1);
        chk("final_toggle1", 32'(bus.ledPattern), 32'h000);
        chk("final_count", 32'(bus.count), 32'd0);
        step(3);
        chk("final_toggle2", 32'(bus.ledPattern), 32'h3FF);
        step(3);
        chk("final_toggle3", 32'(bus.ledPattern), 32'h000);

        // Final -> idle reloads repCount; idle ticks every 4 clks with LEDs dark.
        bus.state = 2'b00;
        step(1);
        chk("idle_entry_rep", 32'(bus.repCount), 32'd2);
        chk("idle_entry_led", 32'(bus.ledPattern), 32'h000);
        chk("idle_entry_count", 32'(bus.count), 32'd0);
        chk("idle_entry_tick", 32'(bus.tick), 32'd0);
        step(3);
        chk("idle_pre_tick", 32'(bus.tick), 32'd0);
        step(1);
        chk("idle_tick1", 32'(bus.tick), 32'd1);
        step(1);
        chk("idle_after_tick", 32'(bus.tick), 32'd0);
        chk("idle_led", 32'(bus.ledPattern), 32'h000);
        chk("idle_count", 32'(bus.count), 32'd0);
        step(3);
        chk("idle_tick2", 32'(bus.tick), 32'd1);

        // Illegal state 11 behaves as idle.
        bus.state = 2'b11;
        step(1);
        chk("s11_entry_tick", 32'(bus.tick), 32'd0);
        step(3);
        chk("s11_pre_tick", 32'(bus.tick), 32'd0);
        step(1);
        chk("s11_tick1", 32'(bus.tick), 32'd1);
        chk("s11_led", 32'(bus.ledPattern), 32'h000);
        step(4);
        chk("s11_tick2", 32'(bus.tick), 32'd1);
        chk("s11_count", 32'(bus.count), 32'd0);
        chk("s11_rep", 32'(bus.repCount), 32'd2);

        // Back to sweep, one wrap, then asynchronous reset at count 5.
        bus.state = 2'b01;
        step(34);
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        chk("pre_rst_led", 32'(bus.ledPattern), 32'h01F);
        chk("pre_rst_rep", 32'(bus.repCount), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_led", 32'(bus.ledPattern), 32'h000);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_rep", 32'(bus.repCount), 32'd2);
        chk("arst_tick", 32'(bus.tick), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
